divisor_nb: RTL

Parametrised button-driven integer divider for the board demo. The operator enters a numerator and a denominator with three active-low push-buttons, and the block computes quotient and remainder with a multi-cycle restoring divider. The operator then steps through the four values on a WIDTH-bit LED bank. It replaces the fixed 4-bit front-end and adds:
- a real division engine,
- input synchronisation and edge detection,
- a divide-by-zero flag,
- a busy indication.

---
 rtl/divisor_nb_pkg.sv | 15 +
 rtl/divisor_nb_seq_core.sv | 74 +++++++
 rtl/divisor_nb.sv | 129 ++++++++++++
 3 files changed

// File: rtl/divisor_nb_pkg.sv
// Shared types and constants for the button-driven divider demo.
package divisor_nb_pkg;

  typedef enum logic [2:0] {
    ST_NUM  = 3'd0,
    ST_DEN  = 3'd1,
    ST_RES  = 3'd2,
    ST_REM  = 3'd3,
    ST_CALC = 3'd4
  } stage_t;

  // Level of an idle (released) active-low button.
  localparam logic BTN_RELEASED = 1'b1;

endpackage

// File: rtl/divisor_nb_seq_core.sv
// Multi-cycle restoring divider: loads on start, then resolves one quotient bit
// per cycle, MSB first, and pulses done on the final step.
module divisor_seq_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] num,
  input  logic [WIDTH-1:0] den,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH:0]   part;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] den_r;
  logic [CNT_W-1:0] cnt;
  logic             running;

  logic [WIDTH+1:0] shifted;
  logic             fits;
  logic [WIDTH:0]   diff;

  // Trial subtraction succeeds when the shifted remainder is at least den.
  function automatic logic trial_fits(input logic [WIDTH+1:0] a, input logic [WIDTH-1:0] b);
    return a >= {2'b00, b};
  endfunction

  always_comb begin
    shifted = {part, quo[WIDTH-1]};
    fits    = trial_fits(shifted, den_r);
    diff    = shifted[WIDTH:0] - {1'b0, den_r};
  end

  // quo starts as the numerator and is shifted out MSB first while quotient
  // bits shift in at the LSB, so it ends holding the quotient.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      part    <= '0;
      quo     <= '0;
      den_r   <= '0;
      cnt     <= '0;
      running <= 1'b0;
    end else if (start && !running) begin
      part    <= '0;
      quo     <= num;
      den_r   <= den;
      cnt     <= '0;
      running <= 1'b1;
    end else if (running) begin
      quo  <= {quo[WIDTH-2:0], fits};
      part <= fits ? diff : shifted[WIDTH:0];
      if (cnt == LAST) begin
        running <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    busy      = running;
    done      = running && (cnt == LAST);
    quotient  = quo;
    remainder = part[WIDTH-1:0];
  end

endmodule

// File: rtl/divisor_nb.sv
// Button front-end, operand counters and stage FSM around the restoring divider;
// the LED bank shows whichever value the current stage selects.
module divisor_nb
  import divisor_nb_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up,
  input  logic             down,
  input  logic             ok,
  output logic [WIDTH-1:0] leds,
  output logic             busy,
  output logic             div_zero
);

  // Bit order in the button vectors: {ok, down, up}.
  logic [2:0] btn_s1;
  logic [2:0] btn_s2;
  logic [2:0] btn_prev;
  logic [2:0] press;
  logic       up_p;
  logic       down_p;
  logic       ok_p;

  stage_t           stage;
  stage_t           stage_next;
  logic [WIDTH-1:0] num;
  logic [WIDTH-1:0] den;
  logic             start;

  logic             core_busy;
  logic             core_done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_s1   <= {3{BTN_RELEASED}};
      btn_s2   <= {3{BTN_RELEASED}};
      btn_prev <= {3{BTN_RELEASED}};
    end else begin
      btn_s1   <= {ok, down, up};
      btn_s2   <= btn_s1;
      btn_prev <= btn_s2;
    end
  end

  // A press is the released-to-pressed edge of the synchronised level.
  always_comb begin
    press  = btn_prev & ~btn_s2;
    up_p   = press[0];
    down_p = press[1];
    ok_p   = press[2];
    start  = (stage == ST_DEN) && ok_p;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage <= ST_NUM;
    end else begin
      stage <= stage_next;
    end
  end

  always_comb begin
    stage_next = stage;
    case (stage)
      ST_NUM:  if (ok_p) stage_next = ST_DEN;
      ST_DEN:  if (ok_p) stage_next = ST_CALC;
      ST_CALC: if (core_done) stage_next = ST_RES;
      ST_RES:  if (ok_p) stage_next = ST_REM;
      ST_REM:  if (ok_p) stage_next = ST_NUM;
      default: stage_next = ST_NUM;
    endcase
  end

  always_comb begin
    leds = '0;
    busy = core_busy;
    case (stage)
      ST_NUM:  leds = num;
      ST_DEN:  leds = den;
      ST_RES:  leds = quotient;
      ST_REM:  leds = remainder;
      default: leds = '0;
    endcase
  end

  // Simultaneous up and down cancel; ok does not block the update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num <= '0;
      den <= '0;
    end else if (up_p != down_p) begin
      if (stage == ST_NUM) begin
        num <= up_p ? num + 1'b1 : num - 1'b1;
      end else if (stage == ST_DEN) begin
        den <= up_p ? den + 1'b1 : den - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_zero <= 1'b0;
    end else if (stage == ST_CALC && stage_next == ST_RES) begin
      div_zero <= (den == '0);
    end else if (stage != ST_NUM && stage_next == ST_NUM) begin
      div_zero <= 1'b0;
    end
  end

  divisor_seq_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .num      (num),
    .den      (den),
    .busy     (core_busy),
    .done     (core_done),
    .quotient (quotient),
    .remainder(remainder)
  );

endmodule
